// File: rtl/fp_ctrl_pkg.sv
// rtl/fp_ctrl_pkg.sv - shared definitions for the floating-point strobe interface
// Holds the responder state encoding and the default widths and timing that both
// the strobe generator and the responder are built with, so both ends agree.
package fp_ctrl_pkg;

  localparam int DATA_W_DEF     = 32;  // mul/add result bus width
  localparam int OPS_W_DEF      = 10;  // operation counter width
  localparam int MUL_PERIOD_DEF = 10;  // generator cycles between mul strobes
  localparam int ADD_LAT_DEF    = 10;  // cycles from a mul strobe to its add strobe

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } fp_state_e;

endpackage

// File: rtl/fp_strobe_delay_line.sv
// rtl/fp_strobe_delay_line.sv - expectation delay line for add strobes
// A DEPTH-deep 1-bit shift register. A 1 entered with an accepted mul strobe
// appears on tap exactly on the cycle its add strobe is due.
// Ports:
//   clk    in  system clock, rising edge
//   rst_n  in  asynchronous active-low reset
//   strobe in  accepted mul strobe
//   tap    out add strobe expected this cycle
module fp_strobe_delay_line
  import fp_ctrl_pkg::*;
#(
  parameter int DEPTH = ADD_LAT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic strobe,
  output logic tap
);

  logic [DEPTH-1:0] sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= '0;
    end else begin
      sr[0] <= strobe;
      for (int i = 1; i < DEPTH; i++) begin
        sr[i] <= sr[i-1];
      end
    end
  end

  assign tap = sr[DEPTH-1];

endmodule

// File: rtl/fp_strobe_responder.sv
// rtl/fp_strobe_responder.sv - consumer end of the floating-point strobe interface
// Enables the strobe generator for a job of num_ops operations, captures the
// multiplier and adder results on their strobes, counts issued and retired
// operations and flags any add strobe that does not land ADD_LAT cycles after
// its mul strobe.
// Optional: define FP_STROBE_WATCHDOG_EN to abort a job whose generator stops
// strobing for 2*MUL_PERIOD cycles while in RUN.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   start, num_ops                  job request and size, sampled in IDLE
//   ena_mul_fp_clk, ena_add_fp_clk  strobes from the generator
//   mul_result, add_result          results valid on their strobes
//   ena_fft_core                    registered enable to the generator
//   mul_hold                        last accepted mul_result
//   result_valid, result_data       one pulse and captured add_result per retire
//   issued_cnt                      mul strobes accepted this job
//   busy, done                      job in progress / one-cycle end pulse
//   proto_err                       sticky protocol error, cleared by start
module fp_strobe_responder
  import fp_ctrl_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int OPS_W      = OPS_W_DEF,
  parameter int MUL_PERIOD = MUL_PERIOD_DEF,
  parameter int ADD_LAT    = ADD_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [OPS_W-1:0]  num_ops,
  input  logic              ena_mul_fp_clk,
  input  logic              ena_add_fp_clk,
  input  logic [DATA_W-1:0] mul_result,
  input  logic [DATA_W-1:0] add_result,
  output logic              ena_fft_core,
  output logic [DATA_W-1:0] mul_hold,
  output logic              result_valid,
  output logic [DATA_W-1:0] result_data,
  output logic [OPS_W-1:0]  issued_cnt,
  output logic              busy,
  output logic              done,
  output logic              proto_err
);

  localparam logic [OPS_W-1:0] ONE = OPS_W'(1);

  fp_state_e        state_q, state_d;
  logic [OPS_W-1:0] num_ops_q;
  logic [OPS_W-1:0] retired_cnt;
  logic             tap;
  logic             active, mul_acc, mul_stray, add_match, add_stray, tap_miss;
  logic             retire, accept, err, wd_abort;

  fp_strobe_delay_line #(.DEPTH(ADD_LAT)) u_delay (
    .clk    (clk),
    .rst_n  (rst_n),
    .strobe (mul_acc),
    .tap    (tap)
  );

  always_comb begin
    state_d   = state_q;
    active    = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    mul_acc   = (state_q == ST_RUN) && ena_mul_fp_clk;
    mul_stray = (state_q != ST_RUN) && ena_mul_fp_clk;
    add_match = active && tap && ena_add_fp_clk;
    // Any add strobe that was not expected, in whatever state, is an error.
    add_stray = ena_add_fp_clk && !(active && tap);
    // A missing add strobe still retires its op so the job can terminate.
    tap_miss  = active && tap && !ena_add_fp_clk;
    retire    = add_match || tap_miss;
    accept    = (state_q == ST_IDLE) && start;
    err       = mul_stray || add_stray || tap_miss || wd_abort;

    case (state_q)
      ST_IDLE: begin
        if (start) state_d = (num_ops != '0) ? ST_RUN : ST_DONE;
      end
      ST_RUN: begin
        if (mul_acc && (issued_cnt + ONE == num_ops_q)) state_d = ST_DRAIN;
        else if (wd_abort)                              state_d = ST_DONE;
      end
      ST_DRAIN: begin
        // Leave on the edge of the final retire so done follows it directly.
        if ((retired_cnt == num_ops_q) ||
            (retire && (retired_cnt + ONE == num_ops_q))) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef FP_STROBE_WATCHDOG_EN
  localparam int WD_W = $clog2(2 * MUL_PERIOD + 1);
  logic [WD_W-1:0] wd_q;

  // The restart cycle counts as the first, so the abort edge is the one on
  // which the count would reach 2*MUL_PERIOD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q <= '0;
    end else if (accept || mul_acc) begin
      wd_q <= WD_W'(1);
    end else if (state_q == ST_RUN) begin
      wd_q <= wd_q + WD_W'(1);
    end
  end

  assign wd_abort = (state_q == ST_RUN) && !ena_mul_fp_clk &&
                    (wd_q == WD_W'(2 * MUL_PERIOD - 1));
`else
  assign wd_abort = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      num_ops_q    <= '0;
      retired_cnt  <= '0;
      issued_cnt   <= '0;
      ena_fft_core <= 1'b0;
      mul_hold     <= '0;
      result_valid <= 1'b0;
      result_data  <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      proto_err    <= 1'b0;
    end else begin
      state_q      <= state_d;
      ena_fft_core <= (state_d == ST_RUN);
      busy         <= (state_d == ST_RUN) || (state_d == ST_DRAIN);
      done         <= (state_q == ST_DONE);
      result_valid <= add_match;
      if (add_match) result_data <= add_result;

      if (accept) begin
        num_ops_q   <= num_ops;
        issued_cnt  <= '0;
        retired_cnt <= '0;
      end else begin
        if (mul_acc) begin
          mul_hold   <= mul_result;
          issued_cnt <= issued_cnt + ONE;
        end
        if (retire) retired_cnt <= retired_cnt + ONE;
      end

      // An error seen on the accepting edge survives the clear.
      if (err)         proto_err <= 1'b1;
      else if (accept) proto_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fp_strobe_responder.sv
// tb/tb_fp_strobe_responder.sv - scoreboard bench for fp_strobe_responder
module tb_fp_strobe_responder;

  localparam int DW = 32;
  localparam int OW = 10;
  localparam int P  = 10;
  localparam int L  = 10;

  logic          clk, rst_n, start;
  logic [OW-1:0] num_ops;
  logic          ena_mul_fp_clk, ena_add_fp_clk;
  logic [DW-1:0] mul_result, add_result;
  logic          ena_fft_core, result_valid, busy, done, proto_err;
  logic [DW-1:0] mul_hold, result_data;
  logic [OW-1:0] issued_cnt;

  fp_strobe_responder #(.DATA_W(DW), .OPS_W(OW), .MUL_PERIOD(P), .ADD_LAT(L)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .num_ops        (num_ops),
    .ena_mul_fp_clk (ena_mul_fp_clk),
    .ena_add_fp_clk (ena_add_fp_clk),
    .mul_result     (mul_result),
    .add_result     (add_result),
    .ena_fft_core   (ena_fft_core),
    .mul_hold       (mul_hold),
    .result_valid   (result_valid),
    .result_data    (result_data),
    .issued_cnt     (issued_cnt),
    .busy           (busy),
    .done           (done),
    .proto_err      (proto_err)
  );

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   done_cyc = -1;
  int   last_valid_cyc = -1;
  int   job_start_cyc = 0;
  int   last_mul_cyc = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard on every result_valid, tracks done pulses.
  always @(negedge clk) begin
    if (result_valid === 1'b1) begin
      last_valid_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("unexpected_result_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("result_data", result_data, e.data);
        check("result_cycle", cyc, e.cyc);
      end
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_ena"}, ena_fft_core, 0);
    check({tag, "_mul_hold"}, mul_hold, 0);
    check({tag, "_rvalid"}, result_valid, 0);
    check({tag, "_rdata"}, result_data, 0);
    check({tag, "_issued"}, issued_cnt, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_perr"}, proto_err, 0);
  endtask

  // Compliant generator model: mul strobe i at cycle 2+i*P after the start
  // edge, its add strobe lat cycles later. rst_after>0 resets after that many muls.
  task automatic drive_job(input int n, input int n_drive, input int lat,
                           input int rst_after, input int tag);
    int dc0;
    @(posedge clk); #1;
    start = 1'b1;
    num_ops = OW'(n);
    job_start_cyc = cyc;
    dc0 = done_cnt;
    @(posedge clk); #1;
    start = 1'b0;
    check("ena_after_start", ena_fft_core, (n != 0));
    check("perr_cleared_by_start", proto_err, 0);
    for (int c = 0; c < 2 + n_drive * P + lat; c++) begin
      int mi, ai;
      logic is_mul, is_add;
      mi = c - 2;
      ai = c - 2 - lat;
      is_mul = (mi >= 0) && (mi % P == 0) && (mi / P < n_drive);
      is_add = (ai >= 0) && (ai % P == 0) && (ai / P < n_drive);
      ena_mul_fp_clk = is_mul;
      mul_result = is_mul ? (32'h1000_0000 | DW'(tag << 8) | DW'(mi / P)) : '0;
      ena_add_fp_clk = is_add;
      add_result = is_add ? (32'hA000_0000 | DW'(tag << 8) | DW'(ai / P)) : '0;
      if (is_add && lat == L) exp_q.push_back('{add_result, cyc + 1});
      if (is_mul) last_mul_cyc = cyc;
      @(posedge clk); #1;
      if (is_mul) begin
        check("issued_cnt", issued_cnt, mi / P + 1);
        check("mul_hold", mul_hold, 32'h1000_0000 | DW'(tag << 8) | DW'(mi / P));
        check("ena_after_mul", ena_fft_core, (mi / P + 1 < n));
        if (rst_after == mi / P + 1) begin
          ena_mul_fp_clk = 1'b0;
          ena_add_fp_clk = 1'b0;
          @(negedge clk); #1;
          rst_n = 1'b0;
          #1;
          check_all_zero("async_reset");
          @(posedge clk); #1;
          rst_n = 1'b1;
          return;
        end
      end
      if (n == 0) check("ena_stays_low", ena_fft_core, 0);
    end
    ena_mul_fp_clk = 1'b0;
    ena_add_fp_clk = 1'b0;
    for (int t = 0; t < 60 && done_cnt == dc0; t++) begin
      @(posedge clk); #1;
    end
    check("done_seen", (done_cnt != dc0), 1);
  endtask

  initial begin
    int dc;
    rst_n = 1'b0;
    start = 1'b0;
    num_ops = '0;
    ena_mul_fp_clk = 1'b0;
    ena_add_fp_clk = 1'b0;
    mul_result = '0;
    add_result = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;

    // Three ops, compliant timing.
    drive_job(3, 3, L, 0, 1);
    check("job3_done_after_retire", done_cyc, last_valid_cyc + 1);
    check("job3_issued", issued_cnt, 3);
    check("job3_perr", proto_err, 0);
    check("job3_busy", busy, 0);

    // Empty job.
    dc = done_cnt;
    drive_job(0, 0, L, 0, 2);
    repeat (3) @(posedge clk);
    #1;
    check("job0_done_cycle", done_cyc, job_start_cyc + 2);
    check("job0_done_once", done_cnt, dc + 1);

    // Add strobe one cycle late.
    drive_job(1, 1, L + 1, 0, 3);
    check("late_add_perr", proto_err, 1);
    check("late_add_issued", issued_cnt, 1);

    // Reset after 2 of 5 ops (start also clears the earlier error).
    drive_job(5, 5, L, 2, 4);

    // Stray mul strobe in IDLE.
    @(posedge clk); #1;
    ena_mul_fp_clk = 1'b1;
    mul_result = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    ena_mul_fp_clk = 1'b0;
    check("idle_mul_perr", proto_err, 1);
    check("idle_mul_issued", issued_cnt, 0);
    check("idle_mul_hold", mul_hold, 0);

    // Fresh single-op job after reset.
    drive_job(1, 1, L, 0, 5);
    check("job1_done_after_retire", done_cyc, last_valid_cyc + 1);
    check("job1_perr", proto_err, 0);

`ifdef FP_STROBE_WATCHDOG_EN
    // Generator stalls after its first strobe.
    drive_job(3, 1, L, 0, 6);
    check("wd_perr", proto_err, 1);
    check("wd_done_cycle", done_cyc, last_mul_cyc + 21);
    check("wd_ena", ena_fft_core, 0);
`endif

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fp_strobe_responder.md
Name: fp_strobe_responder

Overview:
- Consumer end of the floating-point strobe interface: drives ena_fft_core to the strobe generator and consumes its ena_mul_fp_clk / ena_add_fp_clk pulses.
- Captures the multiplier and adder results on those pulses and counts issued and retired operations.
- Checks that every add strobe follows its mul strobe by exactly ADD_LAT cycles, and runs a job of num_ops operations to completion.

Parameters:
- DATA_W, 32: width of mul/add result buses.
- OPS_W, 10: width of the operation counters and num_ops.
- MUL_PERIOD, 10: generator cycles between mul strobes (generator OVERLOAD+1).
- ADD_LAT, 10: cycles from a mul strobe to its add strobe.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle job request; sampled in IDLE only.
- num_ops  in  OPS_W  operations in the job; sampled with start.
- ena_mul_fp_clk  in  1  mul strobe from the generator.
- ena_add_fp_clk  in  1  add strobe from the generator.
- mul_result  in  DATA_W  multiplier output, valid on the mul strobe.
- add_result  in  DATA_W  adder output, valid on the add strobe.
- ena_fft_core  out  1  registered enable to the generator.
- mul_hold  out  DATA_W  last captured mul_result.
- result_valid  out  1  one-cycle pulse per retired op.
- result_data  out  DATA_W  add_result captured with result_valid.
- issued_cnt  out  OPS_W  mul strobes accepted this job.
- busy  out  1  high in RUN or DRAIN.
- done  out  1  one-cycle pulse at job end.
- proto_err  out  1  sticky protocol error; cleared by an accepted start.

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low. All registers and outputs reset to 0; state resets to IDLE.
- Reset mid-job: immediately drops ena_fft_core and abandons the job.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start with num_ops != 0: latch num_ops, clear the counters and proto_err, go to RUN.
  - start with num_ops == 0: go to DONE; ena_fft_core is never raised.
- RUN:
  - ena_fft_core = 1, registered, so it rises the cycle after start.
  - On each mul strobe: mul_hold <= mul_result, issued_cnt += 1, inject a 1 into the ADD_LAT-deep expectation delay line.
  - When the accepted strobe makes issued_cnt equal num_ops: clear ena_fft_core on the same edge and go to DRAIN.
- DRAIN: ena_fft_core = 0. When retired_cnt == num_ops, go to DONE.
- DONE: done = 1 for one cycle, then IDLE.
- Add strobes, in RUN or DRAIN:
  - An add strobe with the delay-line tap = 1 is a match: result_valid = 1 and result_data <= add_result on the next edge (1-cycle latency); retired_cnt += 1.
  - Add strobe with tap = 0: proto_err = 1; no retire.
  - Tap = 1 with no add strobe: proto_err = 1; retired_cnt += 1, so the job still terminates.
- Stray strobes: a mul strobe in IDLE, DRAIN or DONE sets proto_err and is ignored. An add strobe in IDLE sets proto_err.
- Simultaneous mul and add strobes: both are processed in the same cycle.
- start while busy: ignored.
- Counters never wrap, because issued_cnt stops at num_ops.

Optional Feature:
- Macro FP_STROBE_WATCHDOG_EN.
- Defined: a watchdog counter restarts on entry to RUN and on every mul strobe. If it reaches 2*MUL_PERIOD in RUN with no strobe, set proto_err, drop ena_fft_core and go to DONE (abort).
- Undefined: no watchdog logic; RUN waits indefinitely.

Decomposition:
- Shared package fp_ctrl_pkg holds:
  - the state enum;
  - MUL_PERIOD and ADD_LAT defaults, shared with the strobe generator so both ends agree;
  - the DATA_W and OPS_W defaults.
- Sub-module fp_strobe_delay_line: ADD_LAT-deep 1-bit shift register with async reset; input is the accepted mul strobe, output is the expectation tap.

Test Plan:
- start, num_ops=3, compliant generator model: ena_fft_core rises 1 cycle after start; 3 mul strobes spaced 10 cycles; ena_fft_core falls the cycle after the 3rd mul strobe; 3 result_valid pulses each 1 cycle after its add strobe, result_data matching add_result; done 1 cycle after the last retire; proto_err=0.
- start, num_ops=0: done pulses exactly once 2 cycles after start; ena_fft_core stays 0; no result_valid.
- Add strobe delayed to 11 cycles after its mul strobe: proto_err set at cycle 10 (missing) and cycle 11 (unexpected); job still reaches done; a new start clears proto_err.
- rst_n asserted mid-RUN after 2 of 5 ops: all outputs 0 asynchronously; after release the block is in IDLE and a fresh start with num_ops=1 completes normally.
- Mul strobe injected while IDLE: proto_err=1, issued_cnt stays 0.
- With FP_STROBE_WATCHDOG_EN defined, generator stalled after the 1st strobe: proto_err=1 and done pulse 20 cycles after the last strobe.
